// File: rtl/cmprs_tree_acc.sv
// Pipelined 4-to-2 compressor tree that reduces NUM_OPS operands per beat to a
// carry-save pair and accumulates that pair across a packet.
module cmprs_tree_acc #(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 8,
  parameter int OUT_W   = 24,
  parameter int SIGNED  = 0,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_OPS*WIDTH-1:0]   in_ops,
  input  logic                       in_first,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_sum,
  output logic [OUT_W-1:0]           out_carry,
  output logic [CNT_W-1:0]           out_cnt
);

  localparam int LVLS = $clog2(NUM_OPS) - 1;

  if (!(NUM_OPS == 4 || NUM_OPS == 8 || NUM_OPS == 16)) begin : g_bad_num_ops
    $error("cmprs_tree_acc: NUM_OPS must be 4, 8 or 16");
  end
  if (OUT_W < WIDTH + $clog2(NUM_OPS)) begin : g_bad_out_w
    $error("cmprs_tree_acc: OUT_W too narrow for WIDTH and NUM_OPS");
  end

  // One row of 4-to-2 cells; returns {carry, sum}. Top-bit carries fall off (mod 2^OUT_W).
  function automatic logic [2*OUT_W-1:0] csa42(input logic [OUT_W-1:0] a, b, c, d);
    logic [OUT_W-1:0] s;
    logic [OUT_W-1:0] cr;
    logic             t, ca, ca_prev, cb_prev;
    s       = '0;
    cr      = '0;
    ca_prev = 1'b0;
    cb_prev = 1'b0;
    for (int i = 0; i < OUT_W; i++) begin
      t       = a[i] ^ b[i] ^ c[i];
      ca      = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      s[i]    = t ^ d[i] ^ ca_prev;
      cr[i]   = cb_prev;
      cb_prev = (t & d[i]) | (t & ca_prev) | (d[i] & ca_prev);
      ca_prev = ca;
    end
    return {cr, s};
  endfunction

  // Handshake: a beat transfers when in_valid && in_ready, a result when
  // out_valid && out_ready; a held result freezes the whole pipe and drops in_ready.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic [NUM_OPS*WIDTH-1:0]       in_q;
  logic [LVLS:0]                  v_q, f_q, l_q;
  logic [NUM_OPS*OUT_W-1:0]       ext_w;
  logic [(NUM_OPS-2)*OUT_W-1:0]   lvl_q, lvl_d;
  logic [(2*NUM_OPS-2)*OUT_W-1:0] all_w;
  logic [OUT_W-1:0]               t_s, t_c, acc_s, acc_c;
  logic [2*OUT_W-1:0]             acc_d;
  logic [CNT_W-1:0]               acc_cnt;

  always_comb begin
    ext_w = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (SIGNED != 0) ext_w[k*OUT_W +: OUT_W] = OUT_W'($signed(in_q[k*WIDTH +: WIDTH]));
      else             ext_w[k*OUT_W +: OUT_W] = OUT_W'(in_q[k*WIDTH +: WIDTH]);
    end
  end

  // Word-indexed view of every level: extended operands first, then each
  // registered level in order; level g starts at word 2*NUM_OPS - 2*(NUM_OPS>>g).
  assign all_w = {lvl_q, ext_w};
  assign t_s   = all_w[(2*NUM_OPS-4)*OUT_W +: OUT_W];
  assign t_c   = all_w[(2*NUM_OPS-3)*OUT_W +: OUT_W];

  always_comb begin
    int ib;
    int ob;
    logic [2*OUT_W-1:0] quad;
    ib    = 0;
    ob    = 0;
    quad  = '0;
    lvl_d = '0;
    for (int g = 1; g <= LVLS; g++) begin
      for (int k = 0; k < (NUM_OPS >> (g + 1)); k++) begin
        ib   = 2*NUM_OPS - 2*(NUM_OPS >> (g - 1)) + 4*k;
        ob   = NUM_OPS - 2*(NUM_OPS >> g) + 2*k;
        quad = csa42(all_w[ib*OUT_W +: OUT_W],     all_w[(ib+1)*OUT_W +: OUT_W],
                     all_w[(ib+2)*OUT_W +: OUT_W], all_w[(ib+3)*OUT_W +: OUT_W]);
        lvl_d[ob*OUT_W +: 2*OUT_W] = quad;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= '0;
      lvl_q <= '0;
      v_q   <= '0;
      f_q   <= '0;
      l_q   <= '0;
    end else if (!stall) begin
      in_q  <= in_ops;
      lvl_q <= lvl_d;
      v_q   <= {v_q[LVLS-1:0], in_valid};
      f_q   <= {f_q[LVLS-1:0], in_first};
      l_q   <= {l_q[LVLS-1:0], in_last};
    end
  end

  // A first beat folds onto a zero accumulator instead of the running pair.
  assign acc_d = csa42(f_q[LVLS] ? {OUT_W{1'b0}} : acc_s,
                       f_q[LVLS] ? {OUT_W{1'b0}} : acc_c, t_s, t_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_s     <= '0;
      acc_c     <= '0;
      acc_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= v_q[LVLS] && l_q[LVLS];
      if (v_q[LVLS]) begin
        acc_s <= acc_d[OUT_W-1:0];
        acc_c <= acc_d[2*OUT_W-1:OUT_W];
        if (f_q[LVLS])    acc_cnt <= CNT_W'(1);
        else if (!(&acc_cnt)) acc_cnt <= acc_cnt + CNT_W'(1);
      end
    end
  end

  assign out_sum   = acc_s;
  assign out_carry = acc_c;
  assign out_cnt   = acc_cnt;

endmodule

// File: tb/tb_cmprs_tree_acc.sv
// Bench for cmprs_tree_acc: unsigned and signed instances share one stimulus
// stream; results are checked against an expected queue per instance.
module tb_cmprs_tree_acc;

  localparam int WIDTH   = 16;
  localparam int NUM_OPS = 8;
  localparam int OUT_W   = 24;
  localparam int CNT_W   = 8;
  localparam int EW      = OUT_W + CNT_W;
  localparam int OPS_W   = NUM_OPS * WIDTH;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             in_valid, in_first, in_last, out_ready;
  logic [OPS_W-1:0] in_ops;
  logic             in_ready_u, out_valid_u, in_ready_s, out_valid_s;
  logic [OUT_W-1:0] out_sum_u, out_carry_u, out_sum_s, out_carry_s;
  logic [CNT_W-1:0] out_cnt_u, out_cnt_s;

  cmprs_tree_acc #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .OUT_W(OUT_W), .SIGNED(0), .CNT_W(CNT_W)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u), .in_ops(in_ops),
    .in_first(in_first), .in_last(in_last), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_sum(out_sum_u), .out_carry(out_carry_u), .out_cnt(out_cnt_u));

  cmprs_tree_acc #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .OUT_W(OUT_W), .SIGNED(1), .CNT_W(CNT_W)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_ops(in_ops),
    .in_first(in_first), .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_carry(out_carry_s), .out_cnt(out_cnt_s));

  typedef struct {
    logic [OPS_W-1:0] ops;
    int               beats;
    logic [OUT_W-1:0] exp_u;
    logic [OUT_W-1:0] exp_s;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs [6];

  // scoreboard state
  logic [EW-1:0]    exp_q_u [$];
  logic [EW-1:0]    exp_q_s [$];
  logic [OUT_W-1:0] m_u, m_s, tab_u, tab_s;
  logic [CNT_W-1:0] m_cnt, tab_cnt;
  logic             use_tab;
  logic             rnd_done;
  int               pass_cnt = 0;
  int               chk_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_accept(input logic [OPS_W-1:0] ops, input logic f, input logic l);
    logic [WIDTH-1:0] op;
    if (f) begin
      m_u = '0; m_s = '0; m_cnt = '0;
    end
    for (int k = 0; k < NUM_OPS; k++) begin
      op  = ops[k*WIDTH +: WIDTH];
      m_u = m_u + {{(OUT_W-WIDTH){1'b0}}, op};
      m_s = m_s + {{(OUT_W-WIDTH){op[WIDTH-1]}}, op};
    end
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    if (l) begin
      exp_q_u.push_back(use_tab ? {tab_u, tab_cnt} : {m_u, m_cnt});
      exp_q_s.push_back(use_tab ? {tab_s, tab_cnt} : {m_s, m_cnt});
    end
  endtask

  // driver tasks
  task automatic send_beat(input logic [OPS_W-1:0] ops, input logic f, input logic l);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; in_ops = ops; in_first = f; in_last = l;
    #2;
    guard = 0;
    while (!in_ready_u && guard < 200) begin
      @(negedge clk); #2; guard++;
    end
    if (!in_ready_u) check("drv_in_ready_timeout", in_ready_u, 1);
    @(posedge clk);
    #1;
    model_accept(ops, f, l);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_tab(input int i);
    use_tab = 1'b1; tab_u = vecs[i].exp_u; tab_s = vecs[i].exp_s; tab_cnt = vecs[i].exp_cnt;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q_u.size() != 0 || exp_q_s.size() != 0) && guard < 400) begin
      @(negedge clk); guard++;
    end
    repeat (4) @(negedge clk);
    check("drain_q_u", exp_q_u.size(), 0);
    check("drain_q_s", exp_q_s.size(), 0);
  endtask

  function automatic logic [OPS_W-1:0] rand_ops();
    logic [OPS_W-1:0] r;
    int sel;
    r = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      r[k*WIDTH +: WIDTH] = 16'hFFFF;
      else if (sel == 1) r[k*WIDTH +: WIDTH] = 16'h8000;
      else               r[k*WIDTH +: WIDTH] = 16'($urandom_range(0, 65535));
    end
    return r;
  endfunction

  // result monitor: pops one expected entry per accepted result
  logic [EW-1:0]    e_u, e_s;
  logic [OUT_W-1:0] tot_u, tot_s;
  always @(negedge clk) begin
    #1;
    if (rst_n && out_ready) begin
      if (out_valid_u) begin
        if (exp_q_u.size() == 0) check("sb_extra_u", out_valid_u, 0);
        else begin
          e_u   = exp_q_u.pop_front();
          tot_u = out_sum_u + out_carry_u;
          check("sb_total_u", tot_u, e_u[EW-1:CNT_W]);
          check("sb_cnt_u", out_cnt_u, e_u[CNT_W-1:0]);
        end
      end
      if (out_valid_s) begin
        if (exp_q_s.size() == 0) check("sb_extra_s", out_valid_s, 0);
        else begin
          e_s   = exp_q_s.pop_front();
          tot_s = out_sum_s + out_carry_s;
          check("sb_total_s", tot_s, e_s[EW-1:CNT_W]);
          check("sb_cnt_s", out_cnt_s, e_s[CNT_W-1:0]);
        end
      end
    end
  end

  logic [OPS_W-1:0] ramp, ffff, mixed, pow2;
  logic [OUT_W-1:0] cap_sum, cap_carry;
  logic [CNT_W-1:0] cap_cnt;

  initial begin
    ramp  = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    ffff  = {8{16'hFFFF}};
    mixed = {{4{16'h7FFF}}, {4{16'h8000}}};
    pow2  = {16'd128, 16'd64, 16'd32, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1};
    vecs[0] = '{ffff,    1, 24'h07FFF8, 24'hFFFFF8, 8'd1};
    vecs[1] = '{ramp,    3, 24'h00006C, 24'h00006C, 8'd3};
    vecs[2] = '{mixed,   1, 24'h03FFFC, 24'hFFFFFC, 8'd1};
    vecs[3] = '{ramp,    1, 24'h000024, 24'h000024, 8'd1};
    vecs[4] = '{ffff,  300, 24'h5FF6A0, 24'hFFF6A0, 8'd255};
    vecs[5] = '{pow2,    2, 24'h0001FE, 24'h0001FE, 8'd2};

    in_valid = 1'b0; in_ops = '0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    use_tab = 1'b0; rnd_done = 1'b0;
    m_u = '0; m_s = '0; m_cnt = '0; tab_u = '0; tab_s = '0; tab_cnt = '0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid_u", out_valid_u, 0);
    check("rst_out_valid_s", out_valid_s, 0);
    check("rst_out_sum_u", out_sum_u, 0);
    check("rst_out_carry_u", out_carry_u, 0);
    check("rst_out_cnt_u", out_cnt_u, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready_u", in_ready_u, 1);
    check("rst_in_ready_s", in_ready_s, 1);

    // single beat: result appears three cycles after the accepting edge
    set_tab(0);
    send_beat(vecs[0].ops, 1'b1, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat_early", out_valid_u, 0);
    end
    @(negedge clk);
    check("lat_hit", out_valid_u, 1);
    drain();

    // table packets, back to back
    for (int i = 1; i < 6; i++) begin
      set_tab(i);
      for (int b = 0; b < vecs[i].beats; b++)
        send_beat(vecs[i].ops, b == 0, b == vecs[i].beats - 1);
    end
    idle_cycle();
    drain();

    // backpressure with continuous input
    use_tab = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) send_beat({NUM_OPS{16'(k)}}, 1'b1, 1'b1);
        idle_cycle();
      end
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (!out_valid_u && g < 50) begin
          @(negedge clk); g++;
        end
        check("bp_valid", out_valid_u, 1);
        check("bp_in_ready_low", in_ready_u, 0);
        cap_sum = out_sum_u; cap_carry = out_carry_u; cap_cnt = out_cnt_u;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_hold_valid", out_valid_u, 1);
          check("bp_hold_in_ready", in_ready_u, 0);
          check("bp_hold_sum", out_sum_u, cap_sum);
          check("bp_hold_carry", out_carry_u, cap_carry);
          check("bp_hold_cnt", out_cnt_u, cap_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_burst_valid", out_valid_u, 1);
        end
      end
    join
    drain();

    // random packets, bubbles, continuation beats and random out_ready
    rnd_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 25; p++) begin
          int nb;
          logic f0;
          nb = $urandom_range(1, 4);
          f0 = ($urandom_range(0, 3) != 0);
          for (int b = 0; b < nb; b++) begin
            send_beat(rand_ops(), (b == 0) ? f0 : 1'b0, b == nb - 1);
            if ($urandom_range(0, 3) == 0) idle_cycle();
          end
        end
        idle_cycle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // asynchronous reset with a result showing and a packet in flight
    send_beat(ramp, 1'b1, 1'b1);
    send_beat(ramp, 1'b1, 1'b0);
    send_beat(ramp, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_valid", out_valid_u, 1);
    #1;
    rst_n = 1'b0;
    exp_q_u.delete();
    exp_q_s.delete();
    m_u = '0; m_s = '0; m_cnt = '0;
    #1;
    check("async_rst_valid_u", out_valid_u, 0);
    check("async_rst_valid_s", out_valid_s, 0);
    check("async_rst_sum_u", out_sum_u, 0);
    check("async_rst_carry_u", out_carry_u, 0);
    check("async_rst_cnt_u", out_cnt_u, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_tab(3);
    send_beat(ramp, 1'b1, 1'b1);
    idle_cycle();
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
